// File: rtl/rq_reduce_writer_if.sv
// Coefficient stream in, RAM write port and run status out
// for the mod-Q reduce writer.
interface rq_reduce_writer_if #(
   parameter int IN_WIDTH      = 26,
   parameter int RAM_WIDTH     = 13,
   parameter int RAM_ADDR_BITS = 11
);
   logic                     start;
   logic                     in_valid;
   logic [IN_WIDTH-1:0]      in_data;
   logic                     in_ready;
   logic                     write_enable;
   logic [RAM_ADDR_BITS-1:0] write_address;
   logic [RAM_WIDTH-1:0]     input_data;
   logic                     busy;
   logic                     done;

   modport slave (
      input  start, in_valid, in_data,
      output in_ready, write_enable, write_address,
      output input_data, busy, done
   );

   modport master (
      output start, in_valid, in_data,
      input  in_ready, write_enable, write_address,
      input  input_data, busy, done
   );
endinterface

// File: rtl/rq_reduce_writer.sv
// Reduces a stream of 26-bit coefficients mod Q in a 3-stage
// pipeline and writes them to consecutive temp-RAM addresses.
module rq_reduce_writer #(
   parameter int Q             = 4591,
   parameter int N_COEF        = 761,
   parameter int RAM_WIDTH     = 13,
   parameter int RAM_ADDR_BITS = 11,
   parameter int IN_WIDTH      = 26,
   parameter int BASE_ADDR     = 0
) (
   input logic clk,
   input logic rst_n,
   rq_reduce_writer_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;

   localparam int CW = RAM_ADDR_BITS + 1;
   localparam int MW = IN_WIDTH + 1;
   localparam int PW = IN_WIDTH + MW;
   localparam int RW = RAM_WIDTH + 2;
   // floor(2^IN_WIDTH / Q): quotient estimate is low by at most 1
   localparam logic [MW-1:0] M =
      MW'((64'd1 << IN_WIDTH) / 64'(Q));
   localparam logic [RW-1:0] QR = RW'(Q);

   state_t state, state_n;

   logic [CW-1:0]            acc_cnt;
   logic [CW-1:0]            wr_cnt;
   logic [RAM_ADDR_BITS-1:0] addr_cnt;

   logic                     v1, v2;
   logic [IN_WIDTH-1:0]      x1;
   logic [RW-1:0]            r2;
   logic                     we_q;
   logic [RAM_ADDR_BITS-1:0] addr_q;
   logic [RAM_WIDTH-1:0]     data_q;

   logic                     acc;
   logic                     start_run;
   logic [MW-1:0]            qest;
   logic [RW-1:0]            r_n;
   logic [RW-1:0]            s_a, s_b;

   assign acc       = bus.in_valid & (state == RUN);
   assign start_run = bus.start & (state == IDLE);

   assign qest = MW'((PW'(x1) * PW'(M)) >> IN_WIDTH);
   // true remainder < 2Q fits RW bits, so mod-2^RW math is exact
   assign r_n  = RW'(x1) - RW'(qest) * QR;
   assign s_a  = (r2 >= QR) ? r2 - QR : r2;
   assign s_b  = (s_a >= QR) ? s_a - QR : s_a;

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:  if (bus.start) state_n = RUN;
         RUN:   if (acc && acc_cnt == CW'(N_COEF - 1))
                   state_n = DRAIN;
         DRAIN: if (wr_cnt == CW'(N_COEF)) state_n = DONE;
         DONE:  state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_cnt  <= '0;
         wr_cnt   <= '0;
         addr_cnt <= '0;
      end else if (start_run) begin
         acc_cnt  <= '0;
         wr_cnt   <= '0;
         addr_cnt <= '0;
      end else begin
         if (acc)  acc_cnt  <= acc_cnt + 1'b1;
         if (we_q) wr_cnt   <= wr_cnt + 1'b1;
         if (v2)   addr_cnt <= addr_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1     <= 1'b0;
         v2     <= 1'b0;
         x1     <= '0;
         r2     <= '0;
         we_q   <= 1'b0;
         addr_q <= RAM_ADDR_BITS'(BASE_ADDR);
         data_q <= '0;
      end else begin
         v1   <= acc;
         v2   <= v1;
         we_q <= v2;
         if (acc) x1 <= bus.in_data;
         if (v1)  r2 <= r_n;
         if (v2) begin
            data_q <= RAM_WIDTH'(s_b);
            addr_q <= RAM_ADDR_BITS'(BASE_ADDR) + addr_cnt;
         end
      end
   end

   assign bus.in_ready      = (state == RUN);
   assign bus.busy          = (state == RUN) | (state == DRAIN);
   assign bus.done          = (state == DONE);
   assign bus.write_enable  = we_q;
   assign bus.write_address = addr_q;
   assign bus.input_data    = data_q;
endmodule
